mem_access: RTL and testbench

- Memory stage of the RV64 five-stage pipeline. Sits directly downstream of the execute stage and consumes its ex→mem bundle.
- Issues load/store requests on the data bus and holds the pipeline until the bus responds.
- Aligns and extends load data, then registers the write-back bundle for the mem→wb stage.

---
 rtl/mem_access.sv | 165 ++++++++++++++++
 tb/tb_mem_access.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// RV64 memory stage: issues load/store requests, holds the pipeline until the bus answers,
// formats load data and registers the write-back bundle. Optional macro: MEM_MISALIGN_CHECK_EN.
module mem_access #(
  parameter int XLEN   = 64,
  parameter int STRB_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  output logic              dreq_valid,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [STRB_W-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic [XLEN-1:0]   out_wb_data
`ifdef MEM_MISALIGN_CHECK_EN
  ,output logic             out_misalign
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_sdata;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic              r_reg_write;

  logic              w_mem_op;
  logic              w_fault;
  logic              w_accept_mem;
  logic [5:0]        w_shamt;

  function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] raw,
                                               input logic [5:0] shamt,
                                               input logic [2:0] f3);
    logic [XLEN-1:0] s;
    s = raw >> shamt;
    case (f3)
      3'b000:  load_fmt = {{(XLEN-8){s[7]}}, s[7:0]};
      3'b001:  load_fmt = {{(XLEN-16){s[15]}}, s[15:0]};
      3'b010:  load_fmt = {{(XLEN-32){s[31]}}, s[31:0]};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, s[7:0]};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, s[15:0]};
      3'b110:  load_fmt = {{(XLEN-32){1'b0}}, s[31:0]};
      default: load_fmt = s;
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] strobe_fmt(input logic [1:0] size,
                                                   input logic [2:0] off);
    logic [STRB_W-1:0] m;
    case (size)
      2'd0:    m = STRB_W'(8'h01);
      2'd1:    m = STRB_W'(8'h03);
      2'd2:    m = STRB_W'(8'h0F);
      default: m = STRB_W'(8'hFF);
    endcase
    strobe_fmt = m << off;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

  assign w_mem_op = in_mem_read | in_mem_write;
`ifdef MEM_MISALIGN_CHECK_EN
  assign w_fault = w_mem_op & misaligned(in_funct3[1:0], in_alu_result[2:0]);
`else
  assign w_fault = 1'b0;
`endif
  assign w_accept_mem = (r_state == S_IDLE) & in_valid & w_mem_op & ~w_fault;
  assign w_shamt      = {r_addr[2:0], 3'b000};

  // Request is driven straight from the latched bundle so it stays stable through WAIT.
  assign in_ready    = (r_state == S_IDLE);
  assign dreq_valid  = (r_state == S_WAIT);
  assign dreq_addr   = r_addr;
  assign dreq_size   = {1'b0, r_funct3[1:0]};
  assign dreq_strobe = r_store ? strobe_fmt(r_funct3[1:0], r_addr[2:0]) : '0;
  assign dreq_data   = r_sdata << w_shamt;

  always_ff @(posedge clock) begin
    if (w_accept_mem) begin
      r_pc        <= in_pc;
      r_addr      <= in_alu_result;
      r_sdata     <= in_store_data;
      r_store     <= in_mem_write;
      r_funct3    <= in_funct3;
      r_rd        <= in_rd;
      r_reg_write <= in_reg_write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_wb_data   <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      out_misalign  <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_CHECK_EN
      out_misalign <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (in_valid && (!w_mem_op || w_fault)) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write & ~w_fault;
            out_wb_data   <= in_alu_result;
`ifdef MEM_MISALIGN_CHECK_EN
            out_misalign  <= w_fault;
`endif
          end else begin
            out_valid <= 1'b0;
            if (in_valid) r_state <= S_WAIT;
          end
        end
        default: begin
          if (dresp_data_ok) begin
            r_state       <= S_IDLE;
            out_valid     <= 1'b1;
            out_pc        <= r_pc;
            out_rd        <= r_rd;
            out_reg_write <= r_reg_write & ~r_store;
            out_wb_data   <= r_store ? r_addr : load_fmt(dresp_data, w_shamt, r_funct3);
          end else begin
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: driver pushes expectations, a bus responder and
// an output monitor check independently. Honours MEM_MISALIGN_CHECK_EN when defined.
module tb_mem_access;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0, in_alu_result = '0, in_store_data = '0;
  logic        in_mem_read = 1'b0, in_mem_write = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [63:0] out_wb_data;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        out_misalign;
`endif

  always #5 clock = ~clock;

  mem_access #(.XLEN(64), .STRB_W(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_wb_data(out_wb_data)
`ifdef MEM_MISALIGN_CHECK_EN
    , .out_misalign(out_misalign)
`endif
  );

  typedef struct {
    logic [63:0] pc; logic [4:0] rd; logic rw; logic [63:0] wb; logic mis;
  } out_t;
  typedef struct {
    logic [63:0] addr; logic [2:0] size; logic [7:0] strb; logic [63:0] data;
    logic is_store; logic [63:0] rdata; int delay;
  } req_t;

  out_t exp_q[$];
  req_t req_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   busy = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte count from width code, pick bytes starting at the address offset, extend.
  function automatic logic [63:0] ref_load(input logic [63:0] word, input int off, input logic [2:0] f3);
    int nb;
    logic [63:0] s, m, v;
    nb = (f3[1:0] == 2'd3) ? 8 : (1 << f3[1:0]);
    s = word >> (8 * off);
    if (nb == 8) return s;
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = s & m;
    if (!f3[2] && s[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [7:0] ref_strobe(input logic [1:0] sz, input int off);
    logic [15:0] t;
    t = ((16'd1 << (1 << sz)) - 16'd1) << off;
    return t[7:0];
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [63:0] a);
    return (a % (64'd1 << sz)) != 0;
  endfunction

  task automatic issue(input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] sd,
                       input logic [4:0] rd, input logic mr, input logic mw, input logic [2:0] f3,
                       input logic rw, input logic [63:0] rdata, input int delay,
                       input bit has_exp, input logic [63:0] exp_wb);
    int   n;
    int   off;
    bit   fault;
    out_t o;
    req_t r;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
    end
    off = int'(alu[2:0]);
    fault = 0;
`ifdef MEM_MISALIGN_CHECK_EN
    fault = (mr || mw) && ref_misaligned(f3[1:0], alu);
`endif
    o.pc = pc; o.rd = rd; o.mis = 0;
    if (!(mr || mw)) begin
      o.rw = rw; o.wb = alu;
    end else if (fault) begin
      o.rw = 0; o.wb = alu; o.mis = 1;
    end else begin
      r.addr = alu; r.size = {1'b0, f3[1:0]}; r.is_store = mw; r.rdata = rdata;
      r.delay = delay;
      r.strb = mw ? ref_strobe(f3[1:0], off) : 8'h00;
      r.data = sd << (8 * off);
      req_q.push_back(r);
      o.rw = mw ? 1'b0 : rw;
      o.wb = mw ? alu : ref_load(rdata, off, f3);
    end
    if (has_exp) o.wb = exp_wb;
    exp_q.push_back(o);
    in_valid = 1; in_pc = pc; in_alu_result = alu; in_store_data = sd; in_rd = rd;
    in_mem_read = mr; in_mem_write = mw; in_funct3 = f3; in_reg_write = rw;
    @(posedge clock); #1;
    in_valid = 0;
    in_mem_read = 1'($urandom); in_mem_write = 1'($urandom);
    in_alu_result = {$urandom, $urandom}; in_pc = {$urandom, $urandom};
  endtask

  // Bus responder: checks every WAIT cycle's request, answers after the chosen delay.
  initial begin : responder
    req_t cur;
    int   cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy = 0; dresp_data_ok = 0;
      end else if (dresp_data_ok) begin
        dresp_data_ok = 0; busy = 0;
        dresp_data = {$urandom, $urandom};
        check("dreq_valid_after_ok", {63'd0, dreq_valid}, 64'd0);
      end else if (dreq_valid) begin
        if (!busy) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_request: got addr %h expected no request", dreq_addr);
            cnt = -1;
          end else begin
            cur = req_q.pop_front();
            busy = 1; cnt = cur.delay; dresp_data = cur.rdata;
          end
        end
        if (busy) begin
          check("dreq_addr", dreq_addr, cur.addr);
          check("dreq_size", {61'd0, dreq_size}, {61'd0, cur.size});
          check("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, cur.strb});
          if (cur.is_store) check("dreq_data", dreq_data, cur.data);
          check("in_ready_wait", {63'd0, in_ready}, 64'd0);
          if (cnt == 0) dresp_data_ok = 1;
          else cnt--;
        end
      end
    end
  end

  initial begin : monitor
    out_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got pc %h expected no output", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
          check("out_reg_write", {63'd0, out_reg_write}, {63'd0, e.rw});
          check("out_wb_data", out_wb_data, e.wb);
`ifdef MEM_MISALIGN_CHECK_EN
          check("out_misalign", {63'd0, out_misalign}, {63'd0, e.mis});
`endif
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0 || busy) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending outputs expected 0", exp_q.size());
    end
  endtask

  initial begin : driver
    logic [63:0] a;
    logic [2:0]  f3;
    int          kind;
    #1 reset = 1;
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_reg_write", {63'd0, out_reg_write}, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_rd", {59'd0, out_rd}, 64'd0);
    check("rst_out_wb_data", out_wb_data, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 0;

    issue(64'h100, 64'h1234, 64'h0, 5'd5, 0, 0, 3'd0, 1, 64'h0, 0, 1, 64'h1234);
    check("add_in_ready", {63'd0, in_ready}, 64'd1);
    issue(64'h104, 64'h1003, 64'h0, 5'd6, 1, 0, 3'd0, 1, 64'h00000000_80000000, 2, 1, 64'hFFFFFFFF_FFFFFF80);
    issue(64'h108, 64'h2006, 64'h0, 5'd7, 1, 0, 3'd5, 1, 64'hBEEF0000_00000000, 0, 1, 64'h0000BEEF);
    issue(64'h10C, 64'h3005, 64'hAB, 5'd8, 0, 1, 3'd0, 1, 64'h0, 1, 1, 64'h3005);
    drain();

    issue(64'h110, 64'h5000, 64'h0, 5'd9, 1, 0, 3'd3, 1, 64'h1111, 20, 0, 64'h0);
    repeat (3) @(posedge clock);
    #2 reset = 1;
    #1;
    check("rstwait_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    check("rstwait_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstwait_in_ready", {63'd0, in_ready}, 64'd1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(posedge clock); #1 reset = 0;
    issue(64'h114, 64'h77, 64'h0, 5'd10, 0, 0, 3'd0, 1, 64'h0, 0, 1, 64'h77);
    drain();

`ifdef MEM_MISALIGN_CHECK_EN
    issue(64'h118, 64'h4002, 64'h0, 5'd11, 1, 0, 3'd2, 1, 64'h0, 0, 1, 64'h4002);
    drain();
`endif

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 9));
      a = {$urandom, $urandom};
      if (kind < 4) begin
        issue({$urandom, $urandom}, a, 64'h0, 5'($urandom), 0, 0, 3'($urandom), 1'($urandom),
              64'h0, 0, 0, 64'h0);
      end else if (kind < 7) begin
        f3 = 3'($urandom);
`ifdef MEM_MISALIGN_CHECK_EN
        if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
`endif
        issue({$urandom, $urandom}, a, {$urandom, $urandom}, 5'($urandom), 1, 0, f3, 1'($urandom),
              {$urandom, $urandom}, int'($urandom_range(0, 3)), 0, 64'h0);
      end else begin
        f3 = {1'b0, 2'($urandom)};
`ifdef MEM_MISALIGN_CHECK_EN
        if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
`endif
        issue({$urandom, $urandom}, a, {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1, f3,
              1'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)), 0, 64'h0);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
